// File: rtl/poly_synth_pkg.sv
// Shared constants, mix FSM encoding, increment table and triangle conversion for the synth.
// Latency: pure functions and constants; no state.
// Backpressure: none; everything here is combinational.
package poly_synth_pkg;

    localparam int KEYS    = 24;              // key 0 = C4, two octaves
    localparam int VOICES  = 4;               // power of two, 2..16
    localparam int AMP_W   = 9;               // pwm input width
    localparam int PHASE_W = 24;              // increment table assumes 48 kHz ticks
`ifdef ENVELOPE_EN
    localparam int ENV_STEP = 4;              // gain change per processed sample
`endif

    localparam int KW    = $clog2(KEYS);
    localparam int VW    = $clog2(VOICES);
    localparam int ACC_W = AMP_W + VW;        // holds VOICES full-scale samples

    localparam logic [AMP_W-1:0] AMP_HALF = AMP_W'(1 << (AMP_W - 1));

    typedef enum logic [1:0] {
        MIX_IDLE = 2'd0,
        MIX_ACC  = 2'd1,
        MIX_OUT  = 2'd2
    } mix_state_e;

    // Lowest-octave increments, round(440 * 2^((s-9)/12) * 2^24 / 48000).
    function automatic logic [PHASE_W-1:0] base_inc(input int unsigned semi);
        case (semi)
            0:       return 24'd91445;
            1:       return 24'd96882;
            2:       return 24'd102643;
            3:       return 24'd108747;
            4:       return 24'd115213;
            5:       return 24'd122064;
            6:       return 24'd129322;
            7:       return 24'd137012;
            8:       return 24'd145160;
            9:       return 24'd153791;
            10:      return 24'd162936;
            default: return 24'd172625;
        endcase
    endfunction

    // Higher octaves double the base increment once per octave.
    function automatic logic [PHASE_W-1:0] note_inc(input logic [KW-1:0] k);
        int unsigned kk;
        kk = 32'(k);
        return base_inc(kk % 12) << (kk / 12);
    endfunction

    // Rising half for MSB = 0, falling half for MSB = 1; result is signed AMP_W bits.
    function automatic logic signed [AMP_W-1:0] tri_sample(input logic [PHASE_W-1:0] ph);
        logic [AMP_W-1:0] u;
        u = ph[PHASE_W-2 -: AMP_W];
        if (ph[PHASE_W-1])
            return $signed(AMP_HALF - 1'b1 - u);
        else
            return $signed(u - AMP_HALF);
    endfunction

endpackage

// File: rtl/poly_voice_alloc.sv
// Key scanner: one key per cycle, allocates free voices (or steals round-robin), frees on release.
// Latency: a key change is acted on within KEYS cycles; allocation strobe is combinational.
// Backpressure: none; the scanner never stalls and allocation always succeeds.
module poly_voice_alloc import poly_synth_pkg::*; (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [KEYS-1:0]      keys_i,
`ifdef ENVELOPE_EN
    input  logic [VOICES-1:0]    free_i,
    output logic [VOICES-1:0]    rel_o,
`endif
    output logic                 alloc_vld_o,
    output logic [VW-1:0]        alloc_voice_o,
    output logic [VOICES-1:0]    busy_o,
    output logic [VOICES*KW-1:0] note_o,
    output logic                 steal_pulse_o
);

    logic [KW-1:0]     scan_q, scan_d;
    logic [KEYS-1:0]   seen_q, seen_d;
    logic [VOICES-1:0] busy_q, busy_d;
    logic [KW-1:0]     note_q [VOICES];
    logic [KW-1:0]     note_d [VOICES];
    logic [VW-1:0]     steal_ptr_q, steal_ptr_d;
    logic              steal_q, steal_d;
    logic              press, key_rel, any_free;
    logic [VW-1:0]     free_idx, tgt;
`ifdef ENVELOPE_EN
    logic [VOICES-1:0] rel_q, rel_d;
`endif

    // Scan step: detect press/release of the current key and update voice ownership.
    always_comb begin
        press    = keys_i[scan_q] & ~seen_q[scan_q];
        key_rel  = ~keys_i[scan_q] & seen_q[scan_q];
        any_free = ~&busy_q;
        free_idx = '0;
        for (int v = VOICES - 1; v >= 0; v--) begin
            if (!busy_q[v]) free_idx = VW'(v);
        end
        tgt = any_free ? free_idx : steal_ptr_q;

        scan_d      = (scan_q == KW'(KEYS - 1)) ? '0 : scan_q + 1'b1;
        seen_d      = seen_q;
        busy_d      = busy_q;
        note_d      = note_q;
        steal_ptr_d = steal_ptr_q;
        steal_d     = 1'b0;
`ifdef ENVELOPE_EN
        busy_d = busy_q & ~free_i;
        rel_d  = rel_q & ~free_i;
`endif
        if (key_rel) begin
            seen_d[scan_q] = 1'b0;
            for (int v = 0; v < VOICES; v++) begin
                if (busy_q[v] && note_q[v] == scan_q) begin
`ifdef ENVELOPE_EN
                    rel_d[v] = 1'b1;
`else
                    busy_d[v] = 1'b0;
`endif
                end
            end
        end
        // A stolen voice's old key stays seen, so it is not re-allocated until re-pressed.
        if (press) begin
            seen_d[scan_q] = 1'b1;
            busy_d[tgt]    = 1'b1;
            note_d[tgt]    = scan_q;
`ifdef ENVELOPE_EN
            rel_d[tgt] = 1'b0;
`endif
            if (!any_free) begin
                steal_d     = 1'b1;
                steal_ptr_d = steal_ptr_q + 1'b1;
            end
        end
    end

    // Scanner and voice-table registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q      <= '0;
            seen_q      <= '0;
            busy_q      <= '0;
            steal_ptr_q <= '0;
            steal_q     <= 1'b0;
            for (int v = 0; v < VOICES; v++) note_q[v] <= '0;
`ifdef ENVELOPE_EN
            rel_q <= '0;
`endif
        end else begin
            scan_q      <= scan_d;
            seen_q      <= seen_d;
            busy_q      <= busy_d;
            steal_ptr_q <= steal_ptr_d;
            steal_q     <= steal_d;
            note_q      <= note_d;
`ifdef ENVELOPE_EN
            rel_q <= rel_d;
`endif
        end
    end

    // Flatten the note table for the mixer.
    always_comb begin
        for (int v = 0; v < VOICES; v++) note_o[v*KW +: KW] = note_q[v];
    end

    assign alloc_vld_o   = press;
    assign alloc_voice_o = tgt;
    assign busy_o        = busy_q;
    assign steal_pulse_o = steal_q;
`ifdef ENVELOPE_EN
    assign rel_o = rel_q;
`endif

endmodule

// File: rtl/poly_synth_engine.sv
// Polyphonic triangle synth: voice allocator plus per-voice phase accumulators mixed per sample tick.
// Latency: sample_tick to amp_valid is VOICES+1 cycles; ticks during a mix are dropped.
// Backpressure: none; amp_valid is a one-cycle strobe. Optional envelope: define ENVELOPE_EN.
module poly_synth_engine import poly_synth_pkg::*; (
    input  logic              mclk,
    input  logic              reset_n,
    input  logic [KEYS-1:0]   keys,
    input  logic              sample_tick,
    output logic [AMP_W-1:0]  amplitude,
    output logic              amp_valid,
    output logic [VOICES-1:0] voices_busy,
    output logic              steal_pulse
);

    logic [VOICES-1:0]       busy;
    logic [VOICES*KW-1:0]    note_flat;
    logic [KW-1:0]           note [VOICES];
    logic                    alloc_vld;
    logic [VW-1:0]           alloc_voice;

    mix_state_e              state_q, state_d;
    logic [VW-1:0]           vidx_q, vidx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, acc_shr;
    logic [AMP_W-1:0]        amp_q, amp_d;
    logic [PHASE_W-1:0]      phase_q [VOICES];
    logic [PHASE_W-1:0]      phase_d [VOICES];
    logic signed [AMP_W-1:0] sample;
`ifdef ENVELOPE_EN
    logic [VOICES-1:0]       rel, env_free;
    logic [7:0]              gain_q [VOICES];
    logic [7:0]              gain_d [VOICES];
    logic signed [2*AMP_W-1:0] prod;
`endif

    poly_voice_alloc u_alloc (
        .clk           (mclk),
        .rst_n         (reset_n),
        .keys_i        (keys),
`ifdef ENVELOPE_EN
        .free_i        (env_free),
        .rel_o         (rel),
`endif
        .alloc_vld_o   (alloc_vld),
        .alloc_voice_o (alloc_voice),
        .busy_o        (busy),
        .note_o        (note_flat),
        .steal_pulse_o (steal_pulse)
    );

    // Unpack the note table.
    always_comb begin
        for (int v = 0; v < VOICES; v++) note[v] = note_flat[v*KW +: KW];
    end

    // Mixer: one voice per ACC cycle; each voice contributes its pre-advance phase.
    always_comb begin
        state_d = state_q;
        vidx_d  = vidx_q;
        acc_d   = acc_q;
        amp_d   = amp_q;
        phase_d = phase_q;
        sample  = '0;
        acc_shr = '0;
`ifdef ENVELOPE_EN
        gain_d   = gain_q;
        env_free = '0;
        prod     = '0;
`endif
        case (state_q)
            MIX_IDLE: begin
                if (sample_tick) begin
                    state_d = MIX_ACC;
                    acc_d   = '0;
                    vidx_d  = '0;
                end
            end
            MIX_ACC: begin
                if (busy[vidx_q]) begin
                    sample = tri_sample(phase_q[vidx_q]);
`ifdef ENVELOPE_EN
                    prod   = sample * $signed({1'b0, gain_q[vidx_q]});
                    sample = prod[8 +: AMP_W];
                    if (rel[vidx_q]) begin
                        if (gain_q[vidx_q] <= 8'(ENV_STEP)) begin
                            gain_d[vidx_q]   = '0;
                            env_free[vidx_q] = 1'b1;
                        end else begin
                            gain_d[vidx_q] = gain_q[vidx_q] - 8'(ENV_STEP);
                        end
                    end else if (gain_q[vidx_q] > 8'(255 - ENV_STEP)) begin
                        gain_d[vidx_q] = 8'd255;
                    end else begin
                        gain_d[vidx_q] = gain_q[vidx_q] + 8'(ENV_STEP);
                    end
`endif
                    phase_d[vidx_q] = phase_q[vidx_q] + note_inc(note[vidx_q]);
                    acc_d = acc_q + {{VW{sample[AMP_W-1]}}, sample};
                end
                vidx_d = vidx_q + 1'b1;
                // Register the output on the last voice so it is stable during OUT.
                if (vidx_q == VW'(VOICES - 1)) begin
                    state_d = MIX_OUT;
                    acc_shr = acc_d >>> VW;
                    amp_d   = acc_shr[AMP_W-1:0] + AMP_HALF;
                end
            end
            MIX_OUT: state_d = MIX_IDLE;
            default: state_d = MIX_IDLE;
        endcase
        // A fresh allocation wins over the mixer's advance of the same voice.
        if (alloc_vld) begin
            phase_d[alloc_voice] = '0;
`ifdef ENVELOPE_EN
            gain_d[alloc_voice] = '0;
`endif
        end
    end

    // Mixer and phase RAM registers.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MIX_IDLE;
            vidx_q  <= '0;
            acc_q   <= '0;
            amp_q   <= AMP_HALF;
            for (int v = 0; v < VOICES; v++) phase_q[v] <= '0;
`ifdef ENVELOPE_EN
            for (int v = 0; v < VOICES; v++) gain_q[v] <= '0;
`endif
        end else begin
            state_q <= state_d;
            vidx_q  <= vidx_d;
            acc_q   <= acc_d;
            amp_q   <= amp_d;
            phase_q <= phase_d;
`ifdef ENVELOPE_EN
            gain_q <= gain_d;
`endif
        end
    end

    assign amplitude   = amp_q;
    assign amp_valid   = (state_q == MIX_OUT);
    assign voices_busy = busy;

endmodule

// File: tb/tb_poly_synth_engine.sv
// Directed and randomized bench for poly_synth_engine against a note-level reference model.
// Latency: checks amp_valid arrives VOICES+1 cycles after each tick.
// Backpressure: none in the design; the bench only ticks while the mixer is idle.
module tb_poly_synth_engine;

    logic        mclk = 1'b0;
    logic        reset_n;
    logic [23:0] keys;
    logic        sample_tick;
    logic [8:0]  amplitude;
    logic        amp_valid;
    logic [3:0]  voices_busy;
    logic        steal_pulse;

    int checks = 0;
    int errors = 0;
    int steal_cnt = 0;

    // Reference model state: which key each voice plays, its phase, and which keys are held.
    int          m_note  [4];
    bit          m_busy  [4];
    int unsigned m_phase [4];
    bit          m_held  [24];
    int          m_ptr = 0;
    int          m_steals = 0;

    poly_synth_engine dut (
        .mclk        (mclk),
        .reset_n     (reset_n),
        .keys        (keys),
        .sample_tick (sample_tick),
        .amplitude   (amplitude),
        .amp_valid   (amp_valid),
        .voices_busy (voices_busy),
        .steal_pulse (steal_pulse)
    );

    always #5 mclk = ~mclk;

    always @(posedge mclk) if (steal_pulse) steal_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Equal-tempered pitch from A4 = 440 Hz, lowest octave rounded then doubled per octave.
    function automatic int unsigned m_inc(int k);
        real f;
        f = 440.0 * (2.0 ** ((real'(k % 12) - 9.0) / 12.0));
        return int'($rtoi(f * 16777216.0 / 48000.0 + 0.5)) << (k / 12);
    endfunction

    function automatic int m_tri(int unsigned ph);
        int u;
        u = int'((ph >> 14) & 511);
        if (((ph >> 23) & 1) != 0) return 255 - u;
        return u - 256;
    endfunction

    function automatic logic [3:0] m_busy_vec();
        logic [3:0] b;
        for (int v = 0; v < 4; v++) b[v] = m_busy[v];
        return b;
    endfunction

    task automatic m_alloc(input int k);
        int v;
        v = -1;
        for (int i = 3; i >= 0; i--) if (!m_busy[i]) v = i;
        if (v < 0) begin
            v = m_ptr;
            m_ptr = (m_ptr + 1) % 4;
            m_steals++;
        end
        m_note[v] = k; m_busy[v] = 1'b1; m_phase[v] = 0;
    endtask

    task automatic m_tick(output int amp);
        int s;
        s = 0;
        for (int v = 0; v < 4; v++) begin
            if (m_busy[v]) begin
                s += m_tri(m_phase[v]);
                m_phase[v] = (m_phase[v] + m_inc(m_note[v])) & 32'h00FF_FFFF;
            end
        end
        amp = (s >>> 2) + 256;
    endtask

    task automatic set_key(input int k, input bit val);
        @(negedge mclk);
        keys[k] = val;
        m_held[k] = val;
        if (val) m_alloc(k);
        else for (int v = 0; v < 4; v++) if (m_busy[v] && m_note[v] == k) m_busy[v] = 1'b0;
        repeat (24) @(posedge mclk);
        @(negedge mclk);
        chk($sformatf("busy_key%0d_%0d", k, val), voices_busy, m_busy_vec());
    endtask

    task automatic tick_check(input string tag);
        int n, exp_amp;
        m_tick(exp_amp);
        @(negedge mclk); sample_tick = 1'b1;
        @(negedge mclk); sample_tick = 1'b0;
        n = 1;
        while (!amp_valid && n < 20) begin @(negedge mclk); n++; end
        chk({tag, "_lat"}, n, 5);
        chk({tag, "_amp"}, amplitude, exp_amp);
        @(negedge mclk);
        chk({tag, "_vld1"}, amp_valid, 0);
    endtask

    initial begin
        int k, nt, nv;
        reset_n = 1'b0; keys = '0; sample_tick = 1'b0;
        for (int v = 0; v < 4; v++) begin m_busy[v] = 0; m_phase[v] = 0; m_note[v] = 0; end
        for (int i = 0; i < 24; i++) m_held[i] = 0;
        repeat (3) @(negedge mclk);
        chk("rst_amp", amplitude, 256);
        chk("rst_vld", amp_valid, 0);
        chk("rst_busy", voices_busy, 0);
        chk("rst_steal", steal_pulse, 0);
        reset_n = 1'b1;

        // Silence mixes to mid-scale.
        for (int i = 0; i < 3; i++) tick_check($sformatf("idle%0d", i));
        chk("idle_busy", voices_busy, 0);

        // Single A4: first sample from phase 0, second from phase 153791.
        set_key(9, 1'b1);
        tick_check("a4_t0");
        chk("a4_first", amplitude, 192);
        tick_check("a4_t1");
        chk("a4_second", amplitude, 194);
        for (int i = 2; i < 200; i++) tick_check($sformatf("a4_t%0d", i));
        set_key(9, 1'b0);

        // Fill all voices, then steal voice 0.
        set_key(0, 1'b1); set_key(2, 1'b1); set_key(4, 1'b1); set_key(5, 1'b1);
        chk("no_steal_yet", steal_cnt, 0);
        set_key(7, 1'b1);
        chk("steal_once", steal_cnt, 1);
        chk("steal_busy", voices_busy, 4'b1111);
        for (int i = 0; i < 10; i++) tick_check($sformatf("chord%0d", i));

        // Releasing E4 frees voice 2 only.
        set_key(4, 1'b0);
        chk("rel_busy", voices_busy, 4'b1011);
        for (int i = 0; i < 5; i++) tick_check($sformatf("rel%0d", i));

        // Refill the gap, then the next steal must hit voice 1.
        set_key(11, 1'b1);
        chk("refill_nosteal", steal_cnt, 1);
        set_key(1, 1'b1);
        chk("steal_twice", steal_cnt, 2);
        for (int i = 0; i < 5; i++) tick_check($sformatf("steal2_%0d", i));

        // Four fresh voices all at phase 0 give the minimum output.
        for (int i = 0; i < 24; i++) if (m_held[i]) set_key(i, 1'b0);
        chk("all_free", voices_busy, 0);
        set_key(3, 1'b1); set_key(6, 1'b1); set_key(8, 1'b1); set_key(10, 1'b1);
        tick_check("min");
        chk("amp_min", amplitude, 0);
        for (int i = 0; i < 10; i++) tick_check($sformatf("four%0d", i));

        // Random key toggles interleaved with ticks.
        for (int it = 0; it < 40; it++) begin
            k = $urandom_range(0, 23);
            set_key(k, !m_held[k]);
            nt = $urandom_range(1, 6);
            for (int i = 0; i < nt; i++) tick_check($sformatf("rnd%0d_%0d", it, i));
        end
        chk("steal_total", steal_cnt, m_steals);

        // Reset in the middle of a mix: no strobe, everything back to idle.
        @(negedge mclk); sample_tick = 1'b1;
        @(negedge mclk); sample_tick = 1'b0;
        @(posedge mclk); #1 reset_n = 1'b0;
        @(negedge mclk);
        chk("midrst_amp", amplitude, 256);
        chk("midrst_busy", voices_busy, 0);
        chk("midrst_vld", amp_valid, 0);
        @(negedge mclk); reset_n = 1'b1;
        #1;
        chk("postrst_amp", amplitude, 256);
        chk("postrst_busy", voices_busy, 0);
        nv = 0;
        for (int i = 0; i < 12; i++) begin @(negedge mclk); if (amp_valid) nv++; end
        chk("postrst_novld", nv, 0);

        // Held keys re-allocate in ascending scan order after reset.
        for (int v = 0; v < 4; v++) begin m_busy[v] = 0; m_phase[v] = 0; end
        m_ptr = 0;
        for (int i = 0; i < 24; i++) if (m_held[i]) m_alloc(i);
        repeat (24) @(posedge mclk);
        @(negedge mclk);
        chk("realloc_busy", voices_busy, m_busy_vec());
        for (int i = 0; i < 5; i++) tick_check($sformatf("post%0d", i));
        chk("steal_final", steal_cnt, m_steals);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/poly_synth_engine.md
Name: poly_synth_engine

Overview:
- Polyphonic tone generator that replaces the single-note last-key/sine path between the PS/2 key thermometer and the PWM stage.
- Scans the key bitmap, allocates up to VOICES simultaneous notes to voices, and runs a per-voice phase accumulator with a triangle waveform.
- Mixes all voices into one unsigned amplitude word on every sample tick. The word drives the existing pwm block.

Parameters:
- KEYS, 24, keys in bitmap (12 × octaves); key 0 = C4.
- VOICES, 4, simultaneous voices; power of 2, 2..16.
- AMP_W, 9, output amplitude width (matches pwm input).
- PHASE_W, 24, phase accumulator width.
- SAMPLE_HZ, 48000, sample_tick rate used to build the increment table.
- ENV_STEP, 4, envelope gain step per sample (ENVELOPE_EN only).

Ports:
- mclk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- keys  in  KEYS  one bit per key, 1 = held; synchronous to mclk.
- sample_tick  in  1  one-cycle strobe at SAMPLE_HZ.
- amplitude  out  AMP_W  mixed sample, offset binary.
- amp_valid  out  1  one-cycle pulse when amplitude updates.
- voices_busy  out  VOICES  bit v = voice v allocated.
- steal_pulse  out  1  one-cycle pulse when a voice is stolen.

Behaviour:
- Reset state:
  - amplitude = 2^(AMP_W-1) (256 at defaults).
  - amp_valid = 0, voices_busy = 0, steal_pulse = 0.
  - All phases = 0, seen bitmap = 0, scan index = 0, steal_ptr = 0, mix FSM in IDLE.
- Scanner (runs every cycle, independent of the mixer):
  - Index k runs 0..KEYS-1 and wraps to 0; one key per cycle, so a full sweep takes KEYS cycles.
  - Press (keys[k]=1, seen[k]=0):
    - Allocate the lowest-numbered free voice: note ← k, phase ← 0, busy ← 1, seen[k] ← 1.
    - If no voice is free, steal voice steal_ptr (same updates), pulse steal_pulse, and advance steal_ptr modulo VOICES.
    - The stolen voice's old note keeps seen = 1 and is not re-allocated until that key is released and pressed again.
  - Release (keys[k]=0, seen[k]=1):
    - seen[k] ← 0.
    - Every busy voice holding note k enters release; without ENVELOPE_EN it frees (busy ← 0) in the same cycle.
  - Press and release are therefore latched within KEYS cycles of the change.
- Increment table: inc(k) = round(f(k) × 2^PHASE_W / SAMPLE_HZ), where f(k) = 261.63 Hz × 2^(k/12).
  - Built from 12 base-octave constants, left-shifted by k/12.
  - A4 (k = 9) = 153791 at the defaults.
- Mix FSM states: IDLE, ACC, OUT.
  - IDLE → ACC on sample_tick; clears the accumulator and sets v = 0.
  - ACC takes one voice per cycle for VOICES cycles:
    - If busy, phase[v] += inc(note[v]) (wraps mod 2^PHASE_W) and the accumulator adds the triangle sample; otherwise it adds 0.
  - OUT (one cycle): amplitude ← (acc >>> log2(VOICES)) + 2^(AMP_W-1); amp_valid = 1; then → IDLE.
  - Latency from sample_tick to amp_valid = VOICES + 1 cycles.
  - A sample_tick arriving while the FSM is not in IDLE is ignored.
- Triangle sample:
  - m = phase MSB; u = the next AMP_W bits below the MSB.
  - m = 0 → u − 2^(AMP_W-1); m = 1 → 2^(AMP_W-1) − 1 − u.
  - Signed AMP_W bits, range −256..255 at defaults.
- Width rules:
  - Accumulator is signed AMP_W + log2(VOICES) bits and never overflows.
  - amplitude is always in 0..2^AMP_W − 1.
- Scanner write and mixer read of the same voice in one cycle: the mixer uses the pre-write note/phase; the new allocation takes effect on the next tick.
- Asserting reset_n low at any point, including mid-ACC, returns every register to its reset state immediately; no amp_valid is issued for the aborted sample.

Optional Feature:
- ENVELOPE_EN defined:
  - Each voice has an 8-bit gain; the triangle sample is multiplied by gain and shifted right by 8.
  - Gain is set to 0 on allocation and rises by ENV_STEP per processed sample, saturating at 255, while held.
  - In release, gain falls by ENV_STEP per sample; the voice frees when gain reaches 0.
  - A stolen voice restarts at gain 0.
- ENVELOPE_EN undefined: gain is fixed at full scale (no multiply) and voices free immediately on release.

Decomposition:
- Package poly_synth_pkg holds:
  - the 12-entry base increment table and the note_inc(k) function;
  - the mix FSM state enum;
  - the triangle conversion function.
- One sub-module: poly_voice_alloc (scanner, seen bitmap, note/busy registers, steal_ptr). The top level holds the phase RAM and the mixer.

Test Plan:
- Reset, no keys, ticks every 1000 cycles → amplitude = 256, amp_valid 5 cycles after each tick, voices_busy = 0.
- Press key 9 only → within 24 cycles voices_busy = 0001; after 1 tick, phase0 = 153791; amplitude matches the triangle reference model over 200 ticks.
- Press keys 0,2,4,5 then 7 → busy = 1111; exactly one steal_pulse; voice 0 note = 7; steal_ptr = 1.
- Release key 4 (no envelope) → voice 2 busy clears within 24 cycles; its contribution becomes 0 on the next tick.
- Four voices on the same note, phase near peak → amplitude stays within 0..511 (no wrap); min/max reached.
- reset_n low mid-ACC → no amp_valid for that sample; amplitude = 256 and busy = 0 on release of reset.
